open_riscv_soc: RTL and testbench
=================================

# open_riscv_soc

Minimal RV32I system-on-chip: a 3-stage in-order RISC-V integer core (`open_risc_v_inst`) fetching from an instruction ROM (`rom_inst`). It is the top of the design, the unit loaded with riscv-tests programs and run to completion. The bench inspects internal state through hierarchical names. Those names are part of the interface.

## Interface

- Parameters: none. ROM depth is fixed at 4096 × 32-bit words.
- `clk  input  1`  single system clock; all state updates on the rising edge.
- `rst  input  1`  asynchronous, active-low reset; 0 = reset asserted.
- Required hierarchy, probed by benches:
  - `rom_inst.rom_mem[0:4095]` is a 32-bit array loadable by `$readmemh`; word i sits at byte address 4·i.
  - `open_risc_v_inst.regs_inst.regs[0:31]` is the 32 × 32-bit register file.

## Operation

- Pipeline stages:
  - **IF**: the PC addresses the ROM combinationally with `pc[13:2]`. Address bits `pc[31:14]` are ignored, so fetches wrap around the ROM.
  - **ID**: decodes the instruction and reads `rs1`/`rs2` from the register file.
  - **EX**: ALU, branch resolution and register writeback.
- Pipeline registers: IF/ID holds instruction and PC. ID/EX holds the decoded op, both operands, the immediate, `rd`, write-enable and PC.
- Supported instructions, full semantics:
  - LUI, AUIPC, JAL, JALR (target low bit cleared).
  - BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - ADD, SUB, SLL, SLT, SLTU, XOR, OR, AND, SRL, SRA.
- Execute as NOP (no register write, PC+4): loads, stores, FENCE, SYSTEM/CSR, and any unrecognised opcode.
- Arithmetic rules:
  - All arithmetic is 32-bit and wraps modulo 2^32.
  - Shifts use `shamt[4:0]`.
  - Immediates are sign-extended per the RV32I formats.
- Register file:
  - `x0` reads 0 always; writes to it are discarded.
  - Two combinational read ports and one synchronous write port.
  - Internal bypass: if ID reads the register that EX writes in the same cycle, the read returns the EX result.
- Control flow: a taken branch or any jump is resolved in EX.
  - PC loads the target on the next edge.
  - IF/ID and ID/EX are flushed to NOP (`0x00000013`, write-enable 0).
  - JAL/JALR write PC+4 of the jump to `rd`.
- Otherwise the PC advances by 4 each cycle. There are no stalls.

## Timing

- During reset, asynchronously:
  - PC = 0.
  - IF/ID and ID/EX hold NOP with PC 0.
  - `regs[0..31]` = 0.
- First rising edge with `rst`=1: the instruction at address 0 enters IF/ID.
- Latency: an instruction fetched in cycle n is in ID at n+1 and EX at n+2. Its `rd` is updated at the end of n+2, i.e. visible after the 3rd rising edge.
- Back-to-back dependent instructions need no software NOPs:
  - distance 1 is covered by the register-file bypass;
  - distance ≥2 reads the updated register.
- Taken branch/jump: 2 bubble cycles. The first target instruction is in ID two edges after the branch was in EX.
- Not-taken branch: 0 penalty.
- Reset asserted mid-execution: all state returns to its reset values immediately, independent of `clk`. Execution restarts at address 0 after release.

## Test plan

- **Reset**: hold `rst`=0 for 30 ns with a 20 ns clock period -> PC=0 and all regs = 0. After release the first fetch is at address 0.
- **ALU/immediate**: ROM holds ADDI x1,x0,5; ADDI x2,x1,-7; SLTIU x3,x2,1; LUI x4,0x12345 -> x1=5, x2=0xFFFFFFFE, x3=0, x4=0x12345000. Dependent instructions run back-to-back.
- **Branches/flush**: ADDI x1,x0,1; BNE x1,x0,+8; ADDI x5,x0,9; ADDI x6,x0,3 -> x5=0 because the skipped instruction is flushed, x6=3. Repeat with BEQ -> x5=9.
- **Jumps**: JAL x1,+12 at address 0x10 -> x1=0x14. JALR x2,x1,1 -> target 0x14, low bit cleared, and x2 = JALR address+4.
- **Compliance**: load rv32ui-p-addi, then separately rv32ui-p-add (CSR/system instructions executing as NOP) -> when x26 becomes nonzero, x27 must equal 1 one cycle later. Otherwise dump x0..x31.
- **x0 / wrap**: ADDI x0,x0,5 -> x0 stays 0. Branch to 0x4000 -> fetches ROM word 0.

Source files
------------

// File: rtl/open_riscv_soc.sv
// rtl/open_riscv_soc.sv - RV32I 3-stage core (IF/ID/EX) with 4096-word instruction ROM
module rom (
    input  logic [11:0] addr,
    output logic [31:0] data
);
    logic [31:0] rom_mem [0:4095];

    assign data = rom_mem[addr];
endmodule

module regs (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // EX writes back in the same cycle ID reads, so forward the write data
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (raddr1 == 5'd0) rdata1 = '0;
        else if (we && raddr1 == waddr) rdata1 = wdata;
        if (raddr2 == 5'd0) rdata2 = '0;
        else if (we && raddr2 == waddr) rdata2 = wdata;
    end
endmodule

module open_risc_v (
    input  logic        clk,
    input  logic        rst_n,
    output logic [11:0] rom_addr,
    input  logic [31:0] rom_data
);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [4:0] {
        OP_NOP, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
        OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND, OP_SRL, OP_SRA
    } op_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d, ifid_pc_q, ifid_pc_d;
    op_e         idex_op_q, idex_op_d;
    logic [31:0] idex_a_q, idex_a_d, idex_b_q, idex_b_d;
    logic [31:0] idex_imm_q, idex_imm_d, idex_pc_q, idex_pc_d;
    logic [4:0]  idex_rd_q, idex_rd_d;
    logic        idex_we_q, idex_we_d;

    logic [31:0] rs1_val, rs2_val;
    logic [31:0] imm_i, imm_b, imm_j, imm_u;
    logic [2:0]  id_f3;
    op_e         dec_op;
    logic [31:0] dec_imm;
    logic        dec_use_imm, dec_we;
    logic [31:0] ex_res, ex_target;
    logic        ex_taken;

    assign rom_addr = pc_q[13:2];
    assign id_f3    = ifid_instr_q[14:12];
    assign imm_i    = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
    assign imm_b    = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                       ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};
    assign imm_j    = {{11{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[19:12],
                       ifid_instr_q[20], ifid_instr_q[30:21], 1'b0};
    assign imm_u    = {ifid_instr_q[31:12], 12'h000};

    regs regs_inst (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (ifid_instr_q[19:15]),
        .raddr2 (ifid_instr_q[24:20]),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val),
        .we     (idex_we_q),
        .waddr  (idex_rd_q),
        .wdata  (ex_res)
    );

    function automatic op_e alu_op(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? OP_SUB : OP_ADD;
            3'd1:    return OP_SLL;
            3'd2:    return OP_SLT;
            3'd3:    return OP_SLTU;
            3'd4:    return OP_XOR;
            3'd5:    return alt ? OP_SRA : OP_SRL;
            3'd6:    return OP_OR;
            default: return OP_AND;
        endcase
    endfunction

    always_comb begin
        dec_op      = OP_NOP;
        dec_imm     = '0;
        dec_use_imm = 1'b0;
        dec_we      = 1'b0;
        case (ifid_instr_q[6:0])
            7'h37: begin dec_op = OP_LUI;   dec_imm = imm_u; dec_we = 1'b1; end
            7'h17: begin dec_op = OP_AUIPC; dec_imm = imm_u; dec_we = 1'b1; end
            7'h6f: begin dec_op = OP_JAL;   dec_imm = imm_j; dec_we = 1'b1; end
            7'h67: begin dec_op = OP_JALR;  dec_imm = imm_i; dec_we = 1'b1; end
            7'h63: begin
                dec_imm = imm_b;
                case (id_f3)
                    3'd0:    dec_op = OP_BEQ;
                    3'd1:    dec_op = OP_BNE;
                    3'd4:    dec_op = OP_BLT;
                    3'd5:    dec_op = OP_BGE;
                    3'd6:    dec_op = OP_BLTU;
                    3'd7:    dec_op = OP_BGEU;
                    default: dec_op = OP_NOP;
                endcase
            end
            7'h13: begin
                dec_op      = alu_op(id_f3, id_f3 == 3'd5 && ifid_instr_q[30]);
                dec_imm     = imm_i;
                dec_use_imm = 1'b1;
                dec_we      = 1'b1;
            end
            7'h33: begin dec_op = alu_op(id_f3, ifid_instr_q[30]); dec_we = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        ex_res    = '0;
        ex_taken  = 1'b0;
        ex_target = idex_pc_q + idex_imm_q;
        case (idex_op_q)
            OP_LUI:   ex_res = idex_imm_q;
            OP_AUIPC: ex_res = idex_pc_q + idex_imm_q;
            OP_JAL:   begin ex_res = idex_pc_q + 32'd4; ex_taken = 1'b1; end
            OP_JALR:  begin
                ex_res    = idex_pc_q + 32'd4;
                ex_taken  = 1'b1;
                ex_target = (idex_a_q + idex_imm_q) & ~32'd1;
            end
            OP_BEQ:   ex_taken = idex_a_q == idex_b_q;
            OP_BNE:   ex_taken = idex_a_q != idex_b_q;
            OP_BLT:   ex_taken = $signed(idex_a_q) < $signed(idex_b_q);
            OP_BGE:   ex_taken = $signed(idex_a_q) >= $signed(idex_b_q);
            OP_BLTU:  ex_taken = idex_a_q < idex_b_q;
            OP_BGEU:  ex_taken = idex_a_q >= idex_b_q;
            OP_ADD:   ex_res = idex_a_q + idex_b_q;
            OP_SUB:   ex_res = idex_a_q - idex_b_q;
            OP_SLL:   ex_res = idex_a_q << idex_b_q[4:0];
            OP_SLT:   ex_res = {31'd0, $signed(idex_a_q) < $signed(idex_b_q)};
            OP_SLTU:  ex_res = {31'd0, idex_a_q < idex_b_q};
            OP_XOR:   ex_res = idex_a_q ^ idex_b_q;
            OP_OR:    ex_res = idex_a_q | idex_b_q;
            OP_AND:   ex_res = idex_a_q & idex_b_q;
            OP_SRL:   ex_res = idex_a_q >> idex_b_q[4:0];
            OP_SRA:   ex_res = $signed(idex_a_q) >>> idex_b_q[4:0];
            default:  ;
        endcase
    end

    // A taken branch/jump in EX squashes the two younger instructions
    always_comb begin
        pc_d         = ex_taken ? ex_target : pc_q + 32'd4;
        ifid_instr_d = rom_data;
        ifid_pc_d    = pc_q;
        idex_op_d    = dec_op;
        idex_a_d     = rs1_val;
        idex_b_d     = dec_use_imm ? dec_imm : rs2_val;
        idex_imm_d   = dec_imm;
        idex_rd_d    = ifid_instr_q[11:7];
        idex_we_d    = dec_we && ifid_instr_q[11:7] != 5'd0;
        idex_pc_d    = ifid_pc_q;
        if (ex_taken) begin
            ifid_instr_d = NOP;
            ifid_pc_d    = '0;
            idex_op_d    = OP_NOP;
            idex_a_d     = '0;
            idex_b_d     = '0;
            idex_imm_d   = '0;
            idex_rd_d    = '0;
            idex_we_d    = 1'b0;
            idex_pc_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= '0;
            ifid_instr_q <= NOP;
            ifid_pc_q    <= '0;
            idex_op_q    <= OP_NOP;
            idex_a_q     <= '0;
            idex_b_q     <= '0;
            idex_imm_q   <= '0;
            idex_rd_q    <= '0;
            idex_we_q    <= 1'b0;
            idex_pc_q    <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
            idex_op_q    <= idex_op_d;
            idex_a_q     <= idex_a_d;
            idex_b_q     <= idex_b_d;
            idex_imm_q   <= idex_imm_d;
            idex_rd_q    <= idex_rd_d;
            idex_we_q    <= idex_we_d;
            idex_pc_q    <= idex_pc_d;
        end
    end
endmodule

module open_riscv_soc (
    input logic clk,
    input logic rst
);
    logic [11:0] rom_addr;
    logic [31:0] rom_data;

    open_risc_v open_risc_v_inst (
        .clk      (clk),
        .rst_n    (rst),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
    );

    rom rom_inst (
        .addr (rom_addr),
        .data (rom_data)
    );
endmodule

// File: tb/tb_open_riscv_soc.sv
// tb/tb_open_riscv_soc.sv - directed and random-program checks of open_riscv_soc against an ISA model
module tb_open_riscv_soc;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] LOOP = 32'h0000_006f;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    logic [31:0] prog [0:4095];
    logic [31:0] mreg [0:31];

    open_riscv_soc dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] o, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3);
        return {o[12], o[10:5], rs2, rs1, f3, o[4:1], o[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] o, input logic [4:0] rd);
        return {o[20], o[10:1], o[11], o[19:12], rd, 7'h6f};
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                            input logic alt);
        logic [31:0] r;
        case (f3)
            3'd0: r = alt ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: if (alt) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Architectural instruction-at-a-time model; runs until the self-loop jump
    task automatic iss_run();
        logic [31:0] pc, ins, a, b, res, nxt;
        logic [31:0] ii, ib, ij, iu;
        logic        wr, tk;
        for (int r = 0; r < 32; r++) mreg[r] = '0;
        pc = '0;
        for (int s = 0; s < 4000; s++) begin
            ins = prog[pc[13:2]];
            if (ins == LOOP) break;
            a   = mreg[ins[19:15]];
            b   = mreg[ins[24:20]];
            ii  = {{20{ins[31]}}, ins[31:20]};
            ib  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            ij  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            iu  = {ins[31:12], 12'h000};
            nxt = pc + 32'd4;
            wr  = 1'b0;
            res = '0;
            tk  = 1'b0;
            case (ins[6:0])
                7'h37: begin res = iu; wr = 1'b1; end
                7'h17: begin res = pc + iu; wr = 1'b1; end
                7'h6f: begin res = pc + 32'd4; wr = 1'b1; nxt = pc + ij; end
                7'h67: begin res = pc + 32'd4; wr = 1'b1; nxt = (a + ii) & 32'hFFFF_FFFE; end
                7'h63: begin
                    case (ins[14:12])
                        3'd0: tk = (a == b);
                        3'd1: tk = (a != b);
                        3'd4: tk = ($signed(a) < $signed(b));
                        3'd5: tk = ($signed(a) >= $signed(b));
                        3'd6: tk = (a < b);
                        3'd7: tk = (a >= b);
                        default: tk = 1'b0;
                    endcase
                    if (tk) nxt = pc + ib;
                end
                7'h13: begin res = ref_alu(ins[14:12], a, ii, ins[14:12] == 3'd5 && ins[30]); wr = 1'b1; end
                7'h33: begin res = ref_alu(ins[14:12], a, b, ins[30]); wr = 1'b1; end
                default: ;
            endcase
            if (wr && ins[11:7] != 5'd0) mreg[ins[11:7]] = res;
            pc = nxt;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) prog[i] = NOP;
    endtask

    task automatic load_and_reset();
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = prog[i];
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] reg_val(input int r);
        return dut.open_risc_v_inst.regs_inst.regs[r];
    endfunction

    task automatic check_reset_state(input string tag);
        int nz;
        nz = 0;
        for (int r = 0; r < 32; r++) if (reg_val(r) !== 32'd0) nz++;
        check({tag, "_pc"}, dut.open_risc_v_inst.pc_q, 32'd0);
        check({tag, "_ifid_instr"}, dut.open_risc_v_inst.ifid_instr_q, NOP);
        check({tag, "_idex_we"}, {31'd0, dut.open_risc_v_inst.idex_we_q}, 32'd0);
        check({tag, "_nonzero_regs"}, 32'(nz), 32'd0);
    endtask

    task automatic gen_random(input int n);
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm;
        logic [6:0]  op;
        int          skip;
        clear_prog();
        for (int i = 0; i < n; i++) begin
            r    = $urandom();
            rd   = 5'($urandom_range(0, 15));
            rs1  = 5'($urandom_range(0, 15));
            rs2  = 5'($urandom_range(0, 15));
            f3   = r[14:12];
            skip = int'($urandom_range(1, 3));
            if (skip > n - i) skip = n - i;
            case ($urandom_range(0, 9))
                0, 1, 2: prog[i] = enc_r(((f3 == 3'd0 || f3 == 3'd5) && r[30]) ? 7'h20 : 7'h00,
                                         rs2, rs1, f3, rd, 7'h33);
                3, 4, 5: begin
                    imm = r[31:20];
                    if (f3 == 3'd1) imm = {7'h00, r[24:20]};
                    if (f3 == 3'd5) imm = {1'b0, r[30], 5'h00, r[24:20]};
                    prog[i] = enc_i(imm, rs1, f3, rd, 7'h13);
                end
                6: prog[i] = enc_u(r[31:12], rd, 7'h37);
                7: prog[i] = enc_u(r[31:12], rd, 7'h17);
                8: begin
                    if (f3 == 3'd2 || f3 == 3'd3) f3 = f3 + 3'd2;
                    prog[i] = enc_b(32'(skip * 4), rs2, rs1, f3);
                end
                default: begin
                    if (r[0]) prog[i] = enc_j(32'(skip * 4), rd);
                    else begin
                        case (r[2:1])
                            2'd0:    op = 7'h03;
                            2'd1:    op = 7'h23;
                            2'd2:    op = 7'h0f;
                            default: op = 7'h73;
                        endcase
                        prog[i] = {r[31:7], op};
                    end
                end
            endcase
        end
        prog[n] = LOOP;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;

        // reset held across a clock edge
        #25;
        check_reset_state("reset");

        // ALU / immediates, back-to-back dependencies
        clear_prog();
        prog[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        prog[1] = enc_i(12'hFF9, 5'd1, 3'd0, 5'd2, 7'h13);
        prog[2] = enc_i(12'd1, 5'd2, 3'd3, 5'd3, 7'h13);
        prog[3] = enc_u(20'h12345, 5'd4, 7'h37);
        prog[4] = LOOP;
        for (int i = 0; i < 4096; i++) dut.rom_inst.rom_mem[i] = prog[i];
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("first_fetch_instr", dut.open_risc_v_inst.ifid_instr_q, prog[0]);
        check("first_fetch_pc", dut.open_risc_v_inst.ifid_pc_q, 32'd0);
        run(20);
        check("alu_x1", reg_val(1), 32'd5);
        check("alu_x2", reg_val(2), 32'hFFFF_FFFE);
        check("alu_x3", reg_val(3), 32'd0);
        check("alu_x4", reg_val(4), 32'h1234_5000);

        // taken BNE flushes the shadow instruction; BEQ falls through
        for (int v = 0; v < 2; v++) begin
            clear_prog();
            prog[0] = enc_i(12'd1, 5'd0, 3'd0, 5'd1, 7'h13);
            prog[1] = enc_b(32'd8, 5'd0, 5'd1, (v == 0) ? 3'd1 : 3'd0);
            prog[2] = enc_i(12'd9, 5'd0, 3'd0, 5'd5, 7'h13);
            prog[3] = enc_i(12'd3, 5'd0, 3'd0, 5'd6, 7'h13);
            prog[4] = LOOP;
            load_and_reset();
            run(20);
            check((v == 0) ? "bne_x5" : "beq_x5", reg_val(5), (v == 0) ? 32'd0 : 32'd9);
            check((v == 0) ? "bne_x6" : "beq_x6", reg_val(6), 32'd3);
        end

        // JAL link value and JALR low-bit clearing
        clear_prog();
        prog[4] = enc_j(32'd12, 5'd1);
        prog[5] = enc_i(12'd1, 5'd0, 3'd0, 5'd7, 7'h13);
        prog[6] = enc_i(12'd2, 5'd0, 3'd0, 5'd8, 7'h13);
        prog[7] = enc_i(12'd1, 5'd1, 3'd0, 5'd2, 7'h67);
        load_and_reset();
        run(30);
        check("jal_x1", reg_val(1), 32'h14);
        check("jalr_x2", reg_val(2), 32'h20);
        check("jalr_target_x7", reg_val(7), 32'd1);
        check("jalr_path_x8", reg_val(8), 32'd2);

        // x0 is immutable; fetch address wraps at 16 KiB
        clear_prog();
        prog[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13);
        prog[1] = enc_i(12'd1, 5'd9, 3'd0, 5'd9, 7'h13);
        prog[2] = enc_i(12'd2, 5'd0, 3'd0, 5'd11, 7'h13);
        prog[3] = enc_b(32'd8, 5'd11, 5'd9, 3'd0);
        prog[4] = enc_j(32'h3FF0, 5'd0);
        prog[5] = enc_u(20'h00000, 5'd12, 7'h17);
        prog[6] = LOOP;
        load_and_reset();
        run(40);
        check("x0_zero", reg_val(0), 32'd0);
        check("wrap_x9", reg_val(9), 32'd2);
        check("wrap_auipc_x12", reg_val(12), 32'h4014);

        // random programs against the ISA model, one interrupted by reset mid-run
        for (int p = 0; p < 4; p++) begin
            gen_random(40);
            iss_run();
            load_and_reset();
            if (p == 2) begin
                run(25);
                #3;
                rst = 1'b0;
                #1;
                check_reset_state("midrun_reset");
                @(negedge clk);
                rst = 1'b1;
            end
            run(160);
            for (int r = 0; r < 32; r++)
                check($sformatf("rand%0d_x%0d", p, r), reg_val(r), mreg[r]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
